// File: rtl/viterbi_output_packer_if.sv
// Stream bundle shared by the decoded-bit input and the packed-word output.
// A transfer happens on a rising edge where tvalid and tready are both high; tdata/tuser/tlast are only meaningful while tvalid is high.
interface viterbi_output_packer_if #(
  parameter int DW = 1,
  parameter int UW = 1
);
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master    (output tdata, tuser, tvalid, tlast, input tready);
  modport slave     (input tdata, tuser, tvalid, tlast, output tready);
  modport bit_slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/viterbi_output_packer.sv
// Packs decoded bits LSB-first into DATA_WIDTH words and buffers them in a first-word-fall-through FIFO.
// A frame-ending partial word is zero-padded and tagged with its valid-bit count on tuser.
module viterbi_output_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  localparam int BCNT_W = $clog2(DATA_WIDTH) + 1,
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic                       soft_clear,
  viterbi_output_packer_if.bit_slave s_axis,
  viterbi_output_packer_if.master    m_axis,
  output logic [CNT_W-1:0]           fifo_count,
  output logic [15:0]                frame_count,
  output logic                       pack_state
);
  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic {
    FILL = 1'b0,
    LAST = 1'b1
  } pack_state_t;

  pack_state_t           state;
  logic [DATA_WIDTH-1:0] shift;
  logic [IDX_W-1:0]      bit_idx;
  logic [CNT_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      wr_ptr_next;
  logic [CNT_W-1:0]      rd_ptr_next;
  logic [CNT_W-1:0]      count_next;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [BCNT_W-1:0]     mem_user [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;

  logic                  accept;
  logic                  word_done;
  logic                  push;
  logic                  pop;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] word;
  logic [BCNT_W-1:0]     word_bits;
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;

  assign accept     = s_axis.tvalid & ready_q;
  assign word_done  = (&bit_idx) | s_axis.tlast;
  assign push       = accept & word_done & ~soft_clear;
  assign fifo_count = wr_ptr - rd_ptr;
  assign head_valid = (fifo_count != '0);
  assign pop        = head_valid & m_axis.tready & ~soft_clear;
  assign wr_addr    = wr_ptr[AW-1:0];
  assign rd_addr    = rd_ptr[AW-1:0];

  // Bits above bit_idx are already zero in shift, which gives the padding for free.
  always_comb begin
    word          = shift;
    word[bit_idx] = s_axis.tdata[0];
    word_bits     = BCNT_W'(bit_idx) + BCNT_W'(1);
  end

  always_comb begin
    wr_ptr_next = wr_ptr + CNT_W'(push);
    rd_ptr_next = rd_ptr + CNT_W'(pop);
    if (soft_clear) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end
    count_next = wr_ptr_next - rd_ptr_next;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= FILL;
      shift       <= '0;
      bit_idx     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ready_q     <= 1'b0;
      frame_count <= '0;
    end else begin
      wr_ptr  <= wr_ptr_next;
      rd_ptr  <= rd_ptr_next;
      // Ready looks at post-edge occupancy, so a push landing with one slot left still fits.
      ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
      if (soft_clear) begin
        shift   <= '0;
        bit_idx <= '0;
        state   <= FILL;
      end else if (accept) begin
        if (word_done) begin
          shift   <= '0;
          bit_idx <= '0;
          state   <= FILL;
        end else begin
          shift   <= word;
          bit_idx <= bit_idx + IDX_W'(1);
          state   <= (bit_idx == IDX_W'(DATA_WIDTH - 2)) ? LAST : FILL;
        end
      end
      if (push && s_axis.tlast) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (push) begin
      mem_data[wr_addr] <= word;
      mem_user[wr_addr] <= word_bits;
      mem_last[wr_addr] <= s_axis.tlast;
    end
  end

  // Head fields are forced to zero whenever the FIFO is empty, including during reset.
  always_comb begin
    m_axis.tvalid = head_valid;
    m_axis.tdata  = head_valid ? mem_data[rd_addr] : '0;
    m_axis.tuser  = head_valid ? mem_user[rd_addr] : '0;
    m_axis.tlast  = head_valid ? mem_last[rd_addr] : 1'b0;
  end

  assign s_axis.tready = ready_q;
  assign pack_state    = state;

endmodule

// File: tb/tb_viterbi_output_packer.sv
// Directed and randomized stimulus for viterbi_output_packer, checked against a bit-queue packing model.
module tb_viterbi_output_packer;
  localparam int DW     = 32;
  localparam int DEPTH  = 16;
  localparam int BCNT_W = $clog2(DW) + 1;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int EW     = DW + BCNT_W + 1;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic              soft_clear;
  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       frame_count;
  logic              pack_state;

  viterbi_output_packer_if #(.DW(1),  .UW(1))      in_if ();
  viterbi_output_packer_if #(.DW(DW), .UW(BCNT_W)) out_if ();

  viterbi_output_packer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .ACLK        (ACLK),
    .ARESETN     (ARESETN),
    .soft_clear  (soft_clear),
    .s_axis      (in_if),
    .m_axis      (out_if),
    .fifo_count  (fifo_count),
    .frame_count (frame_count),
    .pack_state  (pack_state)
  );

  always #5 ACLK = ~ACLK;

  // Model state: pending input bits {last,data}, bits of the word being built, expected words {last,user,data}.
  logic [1:0]    in_q[$];
  logic          bitq[$];
  logic [EW-1:0] exp_q[$];
  logic [15:0]   fc_exp;
  logic [EW-1:0] held;
  logic [EW-1:0] last_pop;
  logic          stall_prev;
  int            rdy_mode;
  int            gap_pct;
  int            pops;
  int            vectors;
  int            miscompares;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_bit(input logic b, input logic l);
    logic [DW-1:0] w;
    bitq.push_back(b);
    if (l || bitq.size() == DW) begin
      w = '0;
      for (int i = 0; i < bitq.size(); i++) w = w | (DW'(bitq[i]) << i);
      exp_q.push_back({l, BCNT_W'(bitq.size()), w});
      if (l) fc_exp = fc_exp + 16'd1;
      bitq.delete();
    end
  endtask

  task automatic cycle();
    logic [EW-1:0] cur;
    in_if.tvalid = (in_q.size() != 0) && ($urandom_range(99) >= gap_pct);
    in_if.tdata  = (in_q.size() != 0) ? in_q[0][0] : 1'b0;
    in_if.tlast  = (in_q.size() != 0) ? in_q[0][1] : 1'b0;
    case (rdy_mode)
      0:       out_if.tready = 1'b0;
      1:       out_if.tready = 1'b1;
      2:       out_if.tready = ~out_if.tready;
      default: out_if.tready = 1'($urandom_range(1));
    endcase
    @(negedge ACLK);
    cur = {out_if.tlast, out_if.tuser, out_if.tdata};
    check("fifo_count", fifo_count, exp_q.size());
    check("m_tvalid", out_if.tvalid, exp_q.size() != 0);
    check("frame_count", frame_count, fc_exp);
    check("pack_state", pack_state, bitq.size() == DW - 1);
    if (stall_prev && out_if.tvalid) check("stall_hold", cur, held);
    if (in_if.tvalid && in_if.tready) begin
      if (!soft_clear) model_bit(in_q[0][0], in_q[0][1]);
      void'(in_q.pop_front());
    end
    if (out_if.tvalid && out_if.tready && !soft_clear) begin
      if (exp_q.size() == 0) check("pop_unexpected", out_if.tvalid, 1'b0);
      else check("pop_word", cur, exp_q.pop_front());
      pops++;
      last_pop = cur;
    end
    if (soft_clear) begin
      exp_q.delete();
      bitq.delete();
    end
    stall_prev = out_if.tvalid && !out_if.tready && !soft_clear;
    held = cur;
    @(posedge ACLK);
    #1;
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < bound) begin
      cycle();
      n++;
    end
    check("drain_timeout", in_q.size() + exp_q.size(), 0);
  endtask

  task automatic add_random_bits(input int n, input logic last_on_end);
    for (int i = 0; i < n; i++)
      in_q.push_back({last_on_end && (i == n - 1), 1'($urandom_range(1))});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_tready"}, in_if.tready, 1'b0);
    check({tag, "_m_tvalid"}, out_if.tvalid, 1'b0);
    check({tag, "_m_tdata"}, out_if.tdata, '0);
    check({tag, "_m_tuser"}, out_if.tuser, '0);
    check({tag, "_m_tlast"}, out_if.tlast, 1'b0);
    check({tag, "_fifo_count"}, fifo_count, '0);
    check({tag, "_frame_count"}, frame_count, '0);
  endtask

  initial begin
    logic [31:0] pat32;
    logic [4:0]  pat5;
    logic [7:0]  nb;
    int          pops0;
    vectors = 0; miscompares = 0; pops = 0;
    fc_exp = '0; stall_prev = 1'b0; held = '0; last_pop = '0;
    rdy_mode = 1; gap_pct = 0;
    in_if.tvalid = 1'b0; in_if.tdata = 1'b0; in_if.tlast = 1'b0; in_if.tuser = '0;
    out_if.tready = 1'b0;
    soft_clear = 1'b0;
    ARESETN = 1'b0;

    // Reset state and ready rising on the first edge after release.
    repeat (3) @(posedge ACLK);
    #1;
    check_all_zero("reset");
    ARESETN = 1'b1;
    check("tready_before_edge", in_if.tready, 1'b0);
    cycle();
    check("tready_after_edge", in_if.tready, 1'b1);

    // Full word ending a frame.
    pat32 = 32'hA5A5_A5A5;
    for (int i = 0; i < 32; i++) in_q.push_back({i == 31, pat32[i]});
    drain(200);
    check("t1_data", last_pop[DW-1:0], 32'hA5A5_A5A5);
    check("t1_user", last_pop[DW+BCNT_W-1:DW], 32);
    check("t1_last", last_pop[EW-1], 1'b1);
    check("t1_frames", frame_count, 16'd1);

    // Short frame: bits 1,0,1,1,1.
    pat5 = 5'b11101;
    for (int i = 0; i < 5; i++) in_q.push_back({i == 4, pat5[i]});
    drain(100);
    check("t2_data", last_pop[DW-1:0], 32'h0000_001D);
    check("t2_user", last_pop[DW+BCNT_W-1:DW], 5);
    check("t2_last", last_pop[EW-1], 1'b1);

    // Back-pressure until full, then release and expect all 17 words.
    rdy_mode = 0;
    add_random_bits(17 * DW, 1'b0);
    repeat (600) cycle();
    check("t3_count_full", fifo_count, DEPTH);
    check("t3_s_tready", in_if.tready, 1'b0);
    check("t3_bits_left", in_q.size(), DW);
    pops0 = pops;
    rdy_mode = 1;
    drain(1000);
    check("t3_words_out", pops - pops0, 17);
    check("t3_count_empty", fifo_count, '0);

    // Random frames with downstream ready toggling every cycle.
    rdy_mode = 2; gap_pct = 30;
    for (int f = 0; f < 12; f++) add_random_bits($urandom_range(70, 1), 1'b1);
    drain(5000);
    check("t4_frames", frame_count, 16'd14);

    // soft_clear with three words queued and a 12-bit partial word.
    rdy_mode = 0; gap_pct = 0;
    add_random_bits(3 * DW + 12, 1'b0);
    for (int n = 0; n < 300 && in_q.size() != 0; n++) cycle();
    check("t5_count", fifo_count, 3);
    add_random_bits(1, 1'b0);
    soft_clear = 1'b1;
    cycle();
    soft_clear = 1'b0;
    check("t5_tvalid_cleared", out_if.tvalid, 1'b0);
    check("t5_count_cleared", fifo_count, '0);
    check("t5_frames_kept", frame_count, 16'd14);
    rdy_mode = 1;
    nb = 8'($urandom);
    for (int i = 0; i < 8; i++) in_q.push_back({i == 7, nb[i]});
    drain(100);
    check("t5_fresh_data", last_pop[DW-1:0], {24'd0, nb});
    check("t5_fresh_user", last_pop[DW+BCNT_W-1:DW], 8);

    // Asynchronous reset with a full FIFO and an open frame.
    rdy_mode = 0;
    add_random_bits(540, 1'b0);
    repeat (560) cycle();
    check("t6_full", fifo_count, DEPTH);
    #1 ARESETN = 1'b0;
    #1;
    check_all_zero("t6_async");
    in_q.delete(); bitq.delete(); exp_q.delete();
    fc_exp = '0; stall_prev = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    rdy_mode = 1;
    repeat (5) cycle();
    check("t6_tready_back", in_if.tready, 1'b1);
    add_random_bits(40, 1'b1);
    drain(200);
    check("t6_tail_user", last_pop[DW+BCNT_W-1:DW], 8);
    check("t6_frames", frame_count, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
